regfile_write_arbiter: RTL
==========================

# regfile_write_arbiter

Single write port arbiter and destination scoreboard for the 8 x 8-bit register file. It merges two writeback requesters onto the one register-file write port: A is the in-order pipeline writeback, B is the multicycle/load unit. It also tracks which registers have an outstanding B write, so the decode stage can stall on them. The registered write port drives the register file's write-address, write-enable and data inputs directly.

## Interface
- No parameters; widths fixed: 8 registers, 3-bit address, 8-bit data.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- a_valid  in  1  requester A has a write pending.
- a_addr  in  3  A destination register.
- a_data  in  8  A write data.
- a_ready  out  1  A accepted this cycle (combinational).
- b_valid  in  1  requester B has a write pending.
- b_addr  in  3  B destination register.
- b_data  in  8  B write data.
- b_ready  out  1  B accepted this cycle (combinational).
- rsv_valid  in  1  decode issues a B-unit op; reserve its destination.
- rsv_addr  in  3  register to reserve.
- busy  out  8  bit i set = register i has an outstanding B write.
- wr_en  out  1  register file write enable (registered).
- wr_addr  out  3  register file write address (registered).
- wr_data  out  8  register file write data (registered).

## Operation
- Handshake: a transfer occurs on a rising edge where valid and ready are both high. The requester holds addr/data stable while valid is high and not ready.
- At most one grant per cycle:
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the side selected by the round-robin pointer `prio`.
- `prio` selects the side that wins a tie.
  - After any grant, `prio` points to the other requester.
  - With no grant, `prio` is unchanged.
- ready never depends on whether the requested register is busy. No combinational path from wr_* to ready.
- Granted request is latched into wr_en/wr_addr/wr_data on the same edge.
  - With no grant, wr_en = 0 next cycle. wr_addr/wr_data hold their previous values.
- Address 0 (R0, hard-wired zero):
  - The request is still granted and consumes its slot.
  - wr_en is forced 0 for it.
  - rsv to addr 0 never sets busy[0]; busy[0] is always 0.
- Scoreboard:
  - rsv_valid sets busy[rsv_addr] on the edge.
  - A granted B write clears busy[b_addr].
  - Same-edge set and clear of the same address: set wins, because the new reservation supersedes the old one.
  - Reserving an already-busy register keeps it busy (no counting).
- Granted A writes never modify busy.

## Timing
- Reset (rst = 0, asynchronous):
  - wr_en = 0, wr_addr = 0, wr_data = 0.
  - busy = 8'h00.
  - `prio` = A.
- a_ready/b_ready follow the grant rule combinationally; while in reset they are 0.
- Latency:
  - Grant at edge N drives wr_en/wr_addr/wr_data during cycle N..N+1.
  - The register file captures the write at edge N+1.
  - busy updates at edge N.
- Back-to-back grants are allowed every cycle; throughput is 1 write/cycle.
- Under continuous contention, grants strictly alternate A, B, A, B starting from `prio`. Maximum wait is 1 cycle.
- Reset asserted mid-operation:
  - A pending wr_en is dropped; that write is lost.
  - busy clears.
  - Requesters must re-present after reset.
- Deassertion of rst is synchronous to the design: the first grant can occur on the first rising edge after rst goes high.

## Test plan
- Reset: hold rst = 0 with both valid high -> a_ready = b_ready = 0, wr_en = 0, busy = 00. Release -> first edge grants A (wr_addr = a_addr, wr_data = a_data, wr_en = 1 next cycle).
- Contention: a_valid = b_valid = 1 for 6 cycles, A to R3 with 8'h11, B to R5 with 8'h22 -> grant sequence A, B, A, B, A, B; wr_en continuously 1 with alternating addr 3/5.
- Scoreboard: rsv R6 -> busy = 8'h40 next edge; B writes R6 with 8'hAB -> busy = 00 after grant edge; wr_en/R6/AB visible the following cycle.
- Same-edge conflict: B grant to R2 while rsv_valid to R2 -> busy[2] stays 1. A write to a busy R4 -> busy[4] unchanged.
- R0: A writes R0 with 8'hFF -> a_ready = 1, wr_en stays 0. rsv R0 -> busy[0] = 0.
- Mid-operation reset: grant B to R1 with busy[1] = 1, assert rst before the next edge -> wr_en = 0 immediately, busy = 00, and the register file sees no write.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 8 x 8-bit register file: merges the in-order
// writeback (A) and the multicycle/load unit (B), and tracks pending B writes.
module regfile_write_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  input  logic [2:0] a_addr,
  input  logic [7:0] a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [2:0] b_addr,
  input  logic [7:0] b_data,
  output logic       b_ready,
  input  logic       rsv_valid,
  input  logic [2:0] rsv_addr,
  output logic [7:0] busy,
  output logic       wr_en,
  output logic [2:0] wr_addr,
  output logic [7:0] wr_data
);

  localparam int unsigned NREG = 8;
  localparam int unsigned AW   = 3;
  localparam int unsigned DW   = 8;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;

  prio_t           prio;
  logic            grant_a;
  logic            grant_b;
  logic            grant;
  logic [AW-1:0]   grant_addr;
  logic [DW-1:0]   grant_data;
  logic [NREG-1:0] busy_nxt;

  // Grant decision; ready is gated by rst so nothing is accepted during reset.
  always_comb begin
    grant_a    = rst & a_valid & (~b_valid | (prio == PRIO_A));
    grant_b    = rst & b_valid & (~a_valid | (prio == PRIO_B));
    grant      = grant_a | grant_b;
    grant_addr = grant_b ? b_addr : a_addr;
    grant_data = grant_b ? b_data : a_data;
    a_ready    = grant_a;
    b_ready    = grant_b;
  end

  // Reservation is applied after the B clear so a same-edge re-reserve wins.
  always_comb begin
    busy_nxt = busy;
    if (grant_b) busy_nxt[b_addr] = 1'b0;
    if (rsv_valid) busy_nxt[rsv_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio    <= PRIO_A;
      wr_en   <= 1'b0;
      wr_addr <= AW'(0);
      wr_data <= DW'(0);
      busy    <= NREG'(0);
    end else begin
      if (grant_a) prio <= PRIO_B;
      else if (grant_b) prio <= PRIO_A;
      // R0 grants still consume the slot but never reach the register file.
      wr_en <= grant & (grant_addr != AW'(0));
      if (grant) begin
        wr_addr <= grant_addr;
        wr_data <= grant_data;
      end
      busy <= busy_nxt;
    end
  end

endmodule
